// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-box game controller.
// Holds the state encoding, bus widths and the saturating score helper.
package game_pkg;

  localparam int unsigned SCORE_W = 11;
  localparam int unsigned TIMER_W = 6;
  localparam int unsigned BOX_W   = 3;

  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(2047);
  localparam logic [BOX_W-1:0]   BOX_NONE  = BOX_W'(0);

  typedef enum logic [2:0] {
    LOBBY   = 3'd0,
    PICK    = 3'd1,
    ARMED   = 3'd2,
    RELEASE = 3'd3,
    OVER    = 3'd4
  } game_state_e;

  // Score increment that sticks at the top instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler emitting a one-cycle tick every TICKS enabled cycles.
// Ports: clk, resetn (sync, active-low), en (count enable),
//        clr (sync clear, wins over en), tick_c (combinational terminal count).
module sec_tick_gen #(
  parameter int unsigned TICKS = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned       CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == LAST);

  // Counter wraps to zero on the terminal count.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_round_controller.sv
// Top-level sequencer for the whack-a-box game: game-state FSM, round
// timer, target selection from the LFSR and hit scoring.
// Ports: CLOCK_50, resetn (sync, active-low), start_game (pulse),
//        lfsr_value, box_address (0 = none) in; mif_control_signal
//        (target box, 0 = lobby/over), score, game_timer, play_sound
//        (hit pulse), lobby_sound, game_over out. All outputs registered.
module game_round_controller
  import game_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC      = 50000000,
  parameter int unsigned GAME_SECONDS       = 30,
  parameter int unsigned TARGET_TIMEOUT_SEC = 2,
  parameter int unsigned NUM_BOXES          = 6
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start_game,
  input  logic [BOX_W-1:0]   lfsr_value,
  input  logic [BOX_W-1:0]   box_address,
  output logic [BOX_W-1:0]   mif_control_signal,
  output logic [SCORE_W-1:0] score,
  output logic [TIMER_W-1:0] game_timer,
  output logic               play_sound,
  output logic               lobby_sound,
  output logic               game_over
);

  localparam logic [BOX_W-1:0]   MAX_BOX    = BOX_W'(NUM_BOXES);
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(GAME_SECONDS);

  game_state_e        state, state_d;
  logic [BOX_W-1:0]   target, target_d;
  logic [BOX_W-1:0]   prev_target, prev_target_d;
  logic [BOX_W-1:0]   mif_d;
  logic [SCORE_W-1:0] score_d;
  logic [TIMER_W-1:0] timer_d;
  logic               play_d;

  logic in_play, pick_ok, sec_tick, timeout_tick, time_up;

  assign in_play = (state == PICK) || (state == ARMED) || (state == RELEASE);
  assign pick_ok = (lfsr_value != BOX_NONE) && (lfsr_value <= MAX_BOX) &&
                   (lfsr_value != prev_target);
  assign time_up = sec_tick && (game_timer == TIMER_W'(1));

  // Round-second prescaler: runs only while a round is in play.
  sec_tick_gen #(.TICKS(TICKS_PER_SEC)) u_round_tick (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .en     (in_play),
    .clr    ((state == LOBBY) && start_game),
    .tick_c (sec_tick)
  );

  // Target lifetime counter: restarts each time a new target is armed.
  sec_tick_gen #(.TICKS(TARGET_TIMEOUT_SEC * TICKS_PER_SEC)) u_target_tick (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .en     (state == ARMED),
    .clr    ((state == PICK) && pick_ok),
    .tick_c (timeout_tick)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    target_d      = target;
    prev_target_d = prev_target;
    mif_d         = mif_control_signal;
    score_d       = score;
    timer_d       = game_timer;
    play_d        = 1'b0;

    if (in_play && sec_tick) timer_d = game_timer - TIMER_W'(1);

    unique case (state)
      LOBBY: begin
        mif_d = BOX_NONE;
        if (start_game) begin
          state_d = PICK;
          score_d = '0;
          timer_d = TIMER_INIT;
        end
      end
      PICK: begin
        if (pick_ok) begin
          target_d = lfsr_value;
          mif_d    = lfsr_value;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (box_address == target) begin
          state_d       = RELEASE;
          score_d       = sat_inc(score);
          play_d        = 1'b1;
          prev_target_d = target;
          mif_d         = BOX_NONE;
        end else if (timeout_tick) begin
          prev_target_d = target;
          state_d       = PICK;
        end
      end
      RELEASE: begin
        mif_d = BOX_NONE;
        // Wait for the sensor to clear so one strike scores only once.
        if (box_address == BOX_NONE) state_d = PICK;
      end
      OVER: begin
        mif_d = BOX_NONE;
        if (start_game) state_d = LOBBY;
      end
      default: state_d = LOBBY;
    endcase

    // Running out of time overrides any hit or miss on the same edge.
    if (in_play && time_up) begin
      state_d       = OVER;
      mif_d         = BOX_NONE;
      score_d       = score;
      play_d        = 1'b0;
      target_d      = target;
      prev_target_d = prev_target;
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state              <= LOBBY;
      target             <= BOX_NONE;
      prev_target        <= BOX_NONE;
      mif_control_signal <= BOX_NONE;
      score              <= '0;
      game_timer         <= TIMER_INIT;
      play_sound         <= 1'b0;
      lobby_sound        <= 1'b1;
      game_over          <= 1'b0;
    end else begin
      state              <= state_d;
      target             <= target_d;
      prev_target        <= prev_target_d;
      mif_control_signal <= mif_d;
      score              <= score_d;
      game_timer         <= timer_d;
      play_sound         <= play_d;
      lobby_sound        <= (state_d == LOBBY);
      game_over          <= (state_d == OVER);
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Self-checking bench for game_round_controller: directed steps followed by
// randomized play, compared each cycle against a round-level reference model.
// A second instance with a long round exercises score saturation.
module tb_game_round_controller;

  localparam int TPS = 4;
  localparam int GS  = 3;
  localparam int TO  = 1;
  localparam int NB  = 6;

  localparam int PH_LOBBY   = 0;
  localparam int PH_PICK    = 1;
  localparam int PH_ARMED   = 2;
  localparam int PH_RELEASE = 3;
  localparam int PH_OVER    = 4;

  logic        clk = 1'b0;
  logic        resetn, start_game;
  logic [2:0]  lfsr_value, box_address;
  logic [2:0]  mif_control_signal;
  logic [10:0] score;
  logic [5:0]  game_timer;
  logic        play_sound, lobby_sound, game_over;

  logic        s_resetn, s_start;
  logic [2:0]  s_lfsr, s_box, s_mif;
  logic [10:0] s_score;
  logic [5:0]  s_timer;
  logic        s_play, s_lobby, s_over;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_ph, m_played, m_age, m_target, m_prev, m_score, m_timer, m_mif, m_play;

  always #5 clk = ~clk;

  game_round_controller #(
    .TICKS_PER_SEC(TPS), .GAME_SECONDS(GS),
    .TARGET_TIMEOUT_SEC(TO), .NUM_BOXES(NB)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start_game(start_game),
    .lfsr_value(lfsr_value), .box_address(box_address),
    .mif_control_signal(mif_control_signal), .score(score),
    .game_timer(game_timer), .play_sound(play_sound),
    .lobby_sound(lobby_sound), .game_over(game_over)
  );

  game_round_controller #(
    .TICKS_PER_SEC(256), .GAME_SECONDS(63),
    .TARGET_TIMEOUT_SEC(1), .NUM_BOXES(6)
  ) dut_sat (
    .CLOCK_50(clk), .resetn(s_resetn), .start_game(s_start),
    .lfsr_value(s_lfsr), .box_address(s_box),
    .mif_control_signal(s_mif), .score(s_score),
    .game_timer(s_timer), .play_sound(s_play),
    .lobby_sound(s_lobby), .game_over(s_over)
  );

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    assert (got === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Round-level behaviour: time left follows from play cycles elapsed,
  // a target expires after TO*TPS armed cycles.
  task automatic model_step(input bit rn, input bit st, input int lf, input int bx);
    m_play = 0;
    if (!rn) begin
      m_ph = PH_LOBBY; m_score = 0; m_timer = GS; m_mif = 0;
      m_prev = 0; m_target = 0; m_played = 0; m_age = 0;
    end else if (m_ph == PH_LOBBY) begin
      if (st) begin
        m_ph = PH_PICK; m_score = 0; m_timer = GS; m_played = 0;
      end
    end else if (m_ph == PH_OVER) begin
      if (st) m_ph = PH_LOBBY;
    end else begin
      m_played++;
      m_timer = GS - m_played / TPS;
      if (m_timer == 0) begin
        m_ph = PH_OVER; m_mif = 0;
      end else if (m_ph == PH_PICK) begin
        if (lf >= 1 && lf <= NB && lf != m_prev) begin
          m_target = lf; m_mif = lf; m_age = 0; m_ph = PH_ARMED;
        end
      end else if (m_ph == PH_ARMED) begin
        m_age++;
        if (bx == m_target) begin
          m_score = (m_score < 2047) ? m_score + 1 : 2047;
          m_play = 1; m_prev = m_target; m_mif = 0; m_ph = PH_RELEASE;
        end else if (m_age == TO * TPS) begin
          m_prev = m_target; m_ph = PH_PICK;
        end
      end else begin
        if (bx == 0) m_ph = PH_PICK;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mif"},   32'(mif_control_signal), m_mif);
    check({tag, ".score"}, 32'(score),              m_score);
    check({tag, ".timer"}, 32'(game_timer),         m_timer);
    check({tag, ".play"},  32'(play_sound),         m_play);
    check({tag, ".lobby"}, 32'(lobby_sound),        (m_ph == PH_LOBBY) ? 1 : 0);
    check({tag, ".over"},  32'(game_over),          (m_ph == PH_OVER) ? 1 : 0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step(resetn, start_game, int'(lfsr_value), int'(box_address));
    #1;
    check_all(tag);
  endtask

  task automatic sat_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    resetn = 1'b0; start_game = 1'b0; lfsr_value = 3'd0; box_address = 3'd0;
    s_resetn = 1'b0; s_start = 1'b0; s_lfsr = 3'd0; s_box = 3'd0;
    m_ph = PH_LOBBY; m_played = 0; m_age = 0; m_target = 0; m_prev = 0;
    m_score = 0; m_timer = GS; m_mif = 0; m_play = 0;
    #2;

    // Reset and start
    tick("rst0");
    tick("rst1");
    check("rst_timer", 32'(game_timer), 3);
    check("rst_lobby", 32'(lobby_sound), 1);
    check("rst_score", 32'(score), 0);
    check("rst_mif", 32'(mif_control_signal), 0);
    resetn = 1'b1; start_game = 1'b1; lfsr_value = 3'd5;
    tick("start");
    start_game = 1'b0;
    tick("arm5");
    check("arm_mif", 32'(mif_control_signal), 5);

    // Hit, held strike, release
    box_address = 3'd5;
    tick("hit");
    check("hit_score", 32'(score), 1);
    check("hit_sound", 32'(play_sound), 1);
    check("hit_mif", 32'(mif_control_signal), 0);
    repeat (3) tick("hold");
    check("hold_score", 32'(score), 1);
    check("hold_sound", 32'(play_sound), 0);
    check("hold_timer", 32'(game_timer), 2);
    box_address = 3'd0;
    tick("release");

    // Repeat suppression and out-of-range values
    tick("rep5");
    lfsr_value = 3'd0; tick("lfsr0");
    lfsr_value = 3'd7; tick("lfsr7");
    check("skip_mif", 32'(mif_control_signal), 0);
    lfsr_value = 3'd2; tick("lfsr2");
    check("pick2_mif", 32'(mif_control_signal), 2);

    // Round end: hit on the last edge is discarded
    box_address = 3'd3; tick("wrong");
    check("last_timer", 32'(game_timer), 1);
    box_address = 3'd2; tick("end");
    check("end_timer", 32'(game_timer), 0);
    check("end_over", 32'(game_over), 1);
    check("end_score", 32'(score), 1);
    check("end_sound", 32'(play_sound), 0);
    check("end_mif", 32'(mif_control_signal), 0);
    box_address = 3'd0; start_game = 1'b1;
    tick("to_lobby");
    check("lobby_score", 32'(score), 1);
    check("lobby_sound", 32'(lobby_sound), 1);

    // Miss: target expires with wrong or no strike
    lfsr_value = 3'd3;
    tick("start2");
    start_game = 1'b0;
    tick("arm3");
    box_address = 3'd4; tick("wrong1"); tick("wrong2");
    box_address = 3'd0; tick("idle1"); tick("idle2");
    check("miss_score", 32'(score), 0);
    box_address = 3'd3; tick("pick_box3");
    check("miss_no_sound", 32'(play_sound), 0);
    box_address = 3'd0; lfsr_value = 3'd1; tick("arm1");
    check("arm1_mif", 32'(mif_control_signal), 1);

    // Reset during ARMED
    resetn = 1'b0; tick("midrst");
    check("midrst_lobby", 32'(lobby_sound), 1);
    check("midrst_timer", 32'(game_timer), 3);
    check("midrst_mif", 32'(mif_control_signal), 0);
    resetn = 1'b1;

    // Randomized play against the model
    for (int i = 0; i < 400; i++) begin
      resetn      = ($urandom_range(0, 63) != 0);
      start_game  = ($urandom_range(0, 7) == 0);
      lfsr_value  = 3'($urandom_range(0, 7));
      r = int'($urandom_range(0, 3));
      if (r == 0)      box_address = 3'd0;
      else if (r == 1) box_address = 3'(m_target);
      else if (r == 2) box_address = 3'($urandom_range(0, 7));
      tick("rand");
    end

    // Saturation on the long-round instance
    sat_cycle();
    s_resetn = 1'b1; s_start = 1'b1;
    sat_cycle();
    s_start = 1'b0;
    for (int i = 0; i < 2050; i++) begin
      s_lfsr = (i % 2 == 0) ? 3'd1 : 3'd2;
      s_box = 3'd0;
      sat_cycle();
      s_box = s_lfsr;
      sat_cycle();
      if (i == 0)    check("sat_first", 32'(s_score), 1);
      if (i == 2046) check("sat_reach", 32'(s_score), 2047);
      s_box = 3'd0;
      sat_cycle();
    end
    check("sat_hold", 32'(s_score), 2047);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
